reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side counterpart of the operand latches: takes ALU results (destination register + 16-bit value) and commits them to the shared register bank write port.
- Buffers results in a small in-order queue so the ALU does not stall while the bank is busy.
- Exposes a hazard/forward lookup so the operand-fetch stage can see results that are still queued.

Parameters:
- DEPTH, 4: queue entries; power of two, 2..8.
- AW, 3: register address width (8 registers, reg0 = accumulator).
- DW, 16: data width.
- TIMEOUT, 15: consecutive cycles of Reg_wr_en without Reg_wr_ack before Wb_err is set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Wb_valid  in  1  ALU result valid.
- Wb_addr  in  AW  destination register.
- Wb_data  in  DW  result value.
- Wb_ready  out  1  queue can accept this cycle.
- Reg_wr_en  out  1  write request to register bank.
- Reg_wr_addr  out  AW  head entry address.
- Reg_wr_data  out  DW  head entry data.
- Reg_wr_ack  in  1  bank accepted the write this cycle.
- Rd_addr  in  AW  address being fetched by operand stage.
- Rd_hazard  out  1  a queued entry targets Rd_addr.
- Rd_fwd_data  out  DW  youngest queued value for Rd_addr.
- Wb_count  out  log2(DEPTH)+1  current occupancy.
- Wb_err  out  1  sticky bank-timeout flag.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset state:
  - Queue empty; read and write pointers = 0; Wb_count = 0.
  - Wb_ready = 1; Reg_wr_en = 0; Reg_wr_addr = 0; Reg_wr_data = 0.
  - Rd_hazard = 0; Rd_fwd_data = 0; Wb_err = 0; FSM in IDLE; timeout counter = 0.
- Enqueue:
  - Occurs on the rising edge when Wb_valid && Wb_ready.
  - The entry is stored at the write pointer and the pointer wraps modulo DEPTH.
- Wb_ready = (Wb_count != DEPTH).
  - It does not depend on a same-cycle dequeue, so a full queue refuses input even if the head drains that cycle.
- Head output:
  - Reg_wr_en = (Wb_count != 0).
  - Reg_wr_addr and Reg_wr_data come combinationally from the entry at the read pointer; both read 0 when empty.
- Dequeue:
  - Occurs on the rising edge when Reg_wr_en && Reg_wr_ack; read pointer wraps modulo DEPTH.
  - Reg_wr_ack while empty is ignored.
- Latency: an accepted result is first visible on Reg_wr_* the cycle after acceptance. There is no input-to-output bypass when empty.
- Simultaneous enqueue and dequeue leaves Wb_count unchanged; order is strictly FIFO.
- Multiple queued entries to the same address are all written, oldest first.
- FSM:
  - IDLE (empty) -> ACTIVE on enqueue.
  - ACTIVE -> IDLE when the last entry dequeues with no simultaneous enqueue.
  - ACTIVE -> STALL when the timeout counter reaches TIMEOUT.
  - STALL -> ACTIVE on the first Reg_wr_ack.
- Timeout counter:
  - Increments each ACTIVE cycle with Reg_wr_en=1 and Reg_wr_ack=0; clears on ack.
  - Saturates at TIMEOUT.
- Wb_err sets on entry to STALL and stays set until rst. The queue keeps operating in STALL.
- Rd_hazard = OR over valid entries of (entry_addr == Rd_addr). It is combinational, with no added latency.
- An entry dequeuing this cycle still counts as a hazard until the clock edge.
- Reset mid-operation: all queued entries are discarded immediately and no further bank writes are issued.

Optional Feature:
- Macro: REG_WRITEBACK_FWD_EN.
- Defined:
  - Rd_fwd_data = data of the youngest valid entry whose address equals Rd_addr; 0 when Rd_hazard=0.
  - Priority search runs from write pointer minus 1 backward to the read pointer.
- Undefined:
  - Rd_fwd_data is tied to 0 and no priority search is built.
  - Rd_hazard is still produced, so the control unit stalls fetch instead of forwarding.

Test Plan:
- Reset: hold rst=1 with Wb_valid=1 -> Wb_ready=1, Reg_wr_en=0, Wb_count=0, Wb_err=0. Release rst -> queue still empty.
- Single write: Wb_addr=2, Wb_data=0x0064 for one cycle, Reg_wr_ack=1 -> next cycle Reg_wr_en=1, addr 2, data 0x0064; the following cycle Reg_wr_en=0 and Wb_count=0.
- Fill to full: Reg_wr_ack=0, push 5 results (0x000A, 0x03E8, 0x0064, 0x0001, 0x2710) -> first 4 accepted, Wb_ready=0, fifth held. Ack continuously -> bank sees 0x000A, 0x03E8, 0x0064, 0x0001, then 0x2710, in order.
- Same-address forwarding (FWD_EN defined): queue addr 5 = 0x01F4 then addr 5 = 0x1388, Rd_addr=5, no ack -> Rd_hazard=1, Rd_fwd_data=0x1388. Without the macro -> Rd_hazard=1, Rd_fwd_data=0.
- Timeout: one entry queued, Reg_wr_ack=0 for 15 cycles -> Wb_err=1, FSM STALL. Ack -> entry written and Wb_err stays 1.
- Async reset mid-drain: 3 entries queued, assert rst between clock edges -> Reg_wr_en=0 and Wb_count=0 immediately. After release, no write of old data appears.

Source files
------------

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: ALU result, bank write port and operand-fetch lookup signals of reg_writeback.
interface reg_writeback_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          Wb_valid;
  logic [AW-1:0] Wb_addr;
  logic [DW-1:0] Wb_data;
  logic          Wb_ready;
  logic          Reg_wr_en;
  logic [AW-1:0] Reg_wr_addr;
  logic [DW-1:0] Reg_wr_data;
  logic          Reg_wr_ack;
  logic [AW-1:0] Rd_addr;
  logic          Rd_hazard;
  logic [DW-1:0] Rd_fwd_data;
  logic [CW-1:0] Wb_count;
  logic          Wb_err;
  modport slave (
    input  Wb_valid, Wb_addr, Wb_data, Reg_wr_ack, Rd_addr,
    output Wb_ready, Reg_wr_en, Reg_wr_addr, Reg_wr_data, Rd_hazard, Rd_fwd_data, Wb_count, Wb_err
  );
  modport master (
    output Wb_valid, Wb_addr, Wb_data, Reg_wr_ack, Rd_addr,
    input  Wb_ready, Reg_wr_en, Reg_wr_addr, Reg_wr_data, Rd_hazard, Rd_fwd_data, Wb_count, Wb_err
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: in-order queue committing ALU results to the register bank, with hazard lookup.
// Define REG_WRITEBACK_FWD_EN to also forward the youngest queued value for Rd_addr.
module reg_writeback #(
  parameter int DEPTH   = 4,
  parameter int AW      = 3,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  reg_writeback_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, idx;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [DW-1:0] fwd;
  logic          push, pop, drain, haz, err;
  assign wb.Wb_ready    = cnt != CW'(DEPTH);
  assign wb.Reg_wr_en   = cnt != '0;
  assign wb.Reg_wr_addr = wb.Reg_wr_en ? addr_q[rd_ptr] : '0;
  assign wb.Reg_wr_data = wb.Reg_wr_en ? data_q[rd_ptr] : '0;
  assign wb.Wb_count    = cnt;
  assign wb.Wb_err      = err;
  assign wb.Rd_hazard   = haz;
  assign wb.Rd_fwd_data = fwd;
  assign push  = wb.Wb_valid && wb.Wb_ready;
  assign pop   = wb.Reg_wr_en && wb.Reg_wr_ack;
  assign drain = pop && !push && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= wb.Wb_addr;
      data_q[wr_ptr] <= wb.Wb_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      state  <= IDLE;
      err    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      cnt    <= cnt + CW'(push) - CW'(pop);
      tcnt   <= tcnt_nxt;
      state  <= state_nxt;
      if (state_nxt == STALL && state != STALL) err <= 1'b1;
    end
  end
  // Leaving STALL with the last entry draining goes straight to IDLE so the queue-empty state stays consistent.
  always_comb begin
    tcnt_nxt = wb.Reg_wr_ack ? '0 :
               (state == ACTIVE && wb.Reg_wr_en && tcnt != TW'(TIMEOUT)) ? tcnt + 1'b1 : tcnt;
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = push ? ACTIVE : IDLE;
      ACTIVE:  state_nxt = drain ? IDLE : (tcnt_nxt == TW'(TIMEOUT)) ? STALL : ACTIVE;
      STALL:   state_nxt = drain ? IDLE : wb.Reg_wr_ack ? ACTIVE : STALL;
      default: state_nxt = IDLE;
    endcase
  end
  // Scan oldest to youngest so the last match seen is the youngest queued value.
  always_comb begin
    haz = 1'b0;
    fwd = '0;
    idx = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt && addr_q[idx] == wb.Rd_addr) begin
        haz = 1'b1;
`ifdef REG_WRITEBACK_FWD_EN
        fwd = data_q[idx];
`endif
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scoreboard bench for reg_writeback.
module tb_reg_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  reg_writeback_if #(.DEPTH(4), .AW(3), .DW(16)) wb();
  reg_writeback #(.DEPTH(4), .AW(3), .DW(16), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .wb(wb));
  typedef struct packed {logic [2:0] a; logic [15:0] d;} ent_t;
  ent_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  logic last_acc;
`ifdef REG_WRITEBACK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] a, input logic [15:0] d);
    wb.Wb_valid = v;
    wb.Wb_addr  = a;
    wb.Wb_data  = d;
  endtask
  // Checks the pre-edge state against the scoreboard, then advances one clock.
  task automatic cyc();
    logic rdy, en;
    rdy = sb.size() != 4;
    en  = sb.size() != 0;
    check("ready", wb.Wb_ready, rdy);
    check("wr_en", wb.Reg_wr_en, en);
    check("count", wb.Wb_count, sb.size());
    last_acc = wb.Wb_valid && rdy;
    if (en && wb.Reg_wr_ack) begin
      check("wr_addr", wb.Reg_wr_addr, sb[0].a);
      check("wr_data", wb.Reg_wr_data, sb[0].d);
      void'(sb.pop_front());
    end
    if (last_acc) sb.push_back('{a: wb.Wb_addr, d: wb.Wb_data});
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] fv [5];
    int n;
    fv = '{16'h000A, 16'h03E8, 16'h0064, 16'h0001, 16'h2710};
    drive(1'b1, 3'd1, 16'hFFFF);
    wb.Reg_wr_ack = 1'b0;
    wb.Rd_addr    = 3'd1;
    repeat (3) @(negedge clk);
    check("rst_ready", wb.Wb_ready, 1);
    check("rst_en", wb.Reg_wr_en, 0);
    check("rst_count", wb.Wb_count, 0);
    check("rst_err", wb.Wb_err, 0);
    check("rst_hazard", wb.Rd_hazard, 0);
    check("rst_fwd", wb.Rd_fwd_data, 0);
    check("rst_waddr", wb.Reg_wr_addr, 0);
    check("rst_wdata", wb.Reg_wr_data, 0);
    drive(1'b0, 3'd0, 16'h0);
    rst = 1'b0;
    cyc();
    check("post_rst_count", wb.Wb_count, 0);
    drive(1'b1, 3'd2, 16'h0064);
    wb.Reg_wr_ack = 1'b1;
    cyc();
    drive(1'b0, 3'd0, 16'h0);
    check("single_en", wb.Reg_wr_en, 1);
    check("single_addr", wb.Reg_wr_addr, 2);
    check("single_data", wb.Reg_wr_data, 16'h0064);
    cyc();
    check("single_done_en", wb.Reg_wr_en, 0);
    check("single_done_count", wb.Wb_count, 0);
    wb.Reg_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i + 1), fv[i]);
      cyc();
    end
    drive(1'b1, 3'd5, fv[4]);
    check("full_ready", wb.Wb_ready, 0);
    check("full_count", wb.Wb_count, 4);
    cyc();
    check("full_held_count", wb.Wb_count, 4);
    wb.Reg_wr_ack = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 8);
    check("fifth_accepted", last_acc, 1);
    drive(1'b0, 3'd0, 16'h0);
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      cyc();
      n++;
    end
    check("fill_drained_count", wb.Wb_count, 0);
    check("fill_drained_en", wb.Reg_wr_en, 0);
    wb.Reg_wr_ack = 1'b0;
    drive(1'b1, 3'd5, 16'h01F4);
    cyc();
    drive(1'b1, 3'd5, 16'h1388);
    cyc();
    drive(1'b1, 3'd3, 16'h0777);
    cyc();
    drive(1'b0, 3'd0, 16'h0);
    wb.Rd_addr = 3'd5;
    #1;
    check("haz5", wb.Rd_hazard, 1);
    check("fwd5", wb.Rd_fwd_data, FWD ? 16'h1388 : 16'h0);
    wb.Rd_addr = 3'd3;
    #1;
    check("haz3", wb.Rd_hazard, 1);
    check("fwd3", wb.Rd_fwd_data, FWD ? 16'h0777 : 16'h0);
    wb.Rd_addr = 3'd6;
    #1;
    check("haz6", wb.Rd_hazard, 0);
    check("fwd6", wb.Rd_fwd_data, 0);
    wb.Rd_addr    = 3'd5;
    wb.Reg_wr_ack = 1'b1;
    cyc();
    check("haz5_after_pop", wb.Rd_hazard, 1);
    check("fwd5_after_pop", wb.Rd_fwd_data, FWD ? 16'h1388 : 16'h0);
    cyc();
    wb.Rd_addr = 3'd3;
    #1;
    check("haz_dequeuing", wb.Rd_hazard, 1);
    cyc();
    check("haz_gone", wb.Rd_hazard, 0);
    check("haz_drained_count", wb.Wb_count, 0);
    wb.Reg_wr_ack = 1'b0;
    drive(1'b1, 3'd4, 16'hBEEF);
    cyc();
    drive(1'b0, 3'd0, 16'h0);
    repeat (14) cyc();
    check("err_before_timeout", wb.Wb_err, 0);
    cyc();
    check("err_at_timeout", wb.Wb_err, 1);
    check("stall_en", wb.Reg_wr_en, 1);
    wb.Reg_wr_ack = 1'b1;
    cyc();
    check("err_sticky", wb.Wb_err, 1);
    check("stall_drained", wb.Wb_count, 0);
    cyc();
    check("err_still_sticky", wb.Wb_err, 1);
    wb.Reg_wr_ack = 1'b0;
    drive(1'b1, 3'd1, 16'h0011);
    cyc();
    drive(1'b1, 3'd2, 16'h0022);
    cyc();
    drive(1'b1, 3'd3, 16'h0033);
    cyc();
    drive(1'b0, 3'd0, 16'h0);
    check("pre_rst_count", wb.Wb_count, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", wb.Reg_wr_en, 0);
    check("async_rst_count", wb.Wb_count, 0);
    check("async_rst_waddr", wb.Reg_wr_addr, 0);
    check("async_rst_err", wb.Wb_err, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    wb.Reg_wr_ack = 1'b1;
    repeat (4) cyc();
    drive(1'b1, 3'd6, 16'h0ABC);
    cyc();
    drive(1'b0, 3'd0, 16'h0);
    check("post_rst_write_addr", wb.Reg_wr_addr, 6);
    cyc();
    check("final_count", wb.Wb_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
